// File: rtl/if_pkg.sv
// Shared types and constants for the IF/ID fetch queue.
package if_pkg;

    localparam int IFQ_DEPTH = 2;
    localparam logic [31:0] NOP_INSTR = 32'h0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// Generic DEPTH-entry register FIFO of {pc, instr} pairs with push, pop, clear and occupancy count.
// The head is read straight out of the storage registers.
module ifq_fifo
    import if_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [31:0]                wr_pc,
    input  logic [31:0]                wr_instr,
    output logic [31:0]                head_pc,
    output logic [31:0]                head_instr,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    fetch_entry_t       mem_q [DEPTH];
    fetch_entry_t       mem_d [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]     count_q, count_d;

    // Next-state: clear wins; otherwise write at wr_ptr, advance pointers (power-of-two wrap) and track count.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = '{pc: wr_pc, instr: wr_instr};
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Storage and pointer registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '{pc: 32'h0, instr: NOP_INSTR};
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // The parent's issue credit must never let an unmatched push land on a full queue.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && !pop && !clear && count_q == FULL_COUNT));
        end
    end

    assign head_pc    = mem_q[rd_ptr_q].pc;
    assign head_instr = mem_q[rd_ptr_q].instr;
    assign count      = count_q;

endmodule

// File: rtl/if_id_fetch_queue.sv
// IF/ID fetch queue: issues word reads to 1-cycle instruction memory, buffers {pc, instr}
// responses in a small FIFO and presents the head as the IF/ID register.
// Optional macro IFQ_PERF_CNT_EN adds flush_counter / stall_counter outputs.
module if_id_fetch_queue
    import if_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt,
    input  logic        pc_bj,
    input  logic        id_stall,
    input  logic [31:0] pc_in,
    input  logic [31:0] imem_rdata,
    output logic        imem_en,
    output logic [31:0] imem_addr,
    output logic [31:0] pc_if_id,
    output logic [31:0] instr_if_id,
    output logic        valid_if_id,
    output logic        fetch_hold
`ifdef IFQ_PERF_CNT_EN
    ,
    output logic [31:0] flush_counter,
    output logic [31:0] stall_counter
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W+1:0] DEPTH_OCC = (PTR_W + 2)'(DEPTH);

    logic [PTR_W:0]   count;
    logic [31:0]      head_pc;
    logic [31:0]      head_instr;
    logic             pop;
    logic             push;
    logic             issue;
    logic [PTR_W+1:0] occ;
    logic             inflight_v_q, inflight_v_d;
    logic [31:0]      inflight_pc_q, inflight_pc_d;
    fetch_entry_t     hold_q, hold_d;

    ifq_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .clear      (pc_bj),
        .push       (push),
        .pop        (pop),
        .wr_pc      (inflight_pc_q),
        .wr_instr   (imem_rdata),
        .head_pc    (head_pc),
        .head_instr (head_instr),
        .count      (count)
    );

    // Credit, flush and halt control; occupancy counts the in-flight read so a response always has a slot.
    always_comb begin
        valid_if_id   = (count != '0);
        pop           = valid_if_id & ~id_stall & ~halt & ~pc_bj;
        push          = inflight_v_q & ~pc_bj;
        occ           = (PTR_W + 2)'(count) + (PTR_W + 2)'(inflight_v_q) - (PTR_W + 2)'(pop);
        issue         = ~halt & (pc_bj | (occ < DEPTH_OCC));
        fetch_hold    = ~halt & ~pc_bj & (occ >= DEPTH_OCC);
        imem_en       = issue & ~rst;
        imem_addr     = pc_in;
        inflight_v_d  = issue;
        inflight_pc_d = issue ? pc_in : inflight_pc_q;
        hold_d        = valid_if_id ? '{pc: head_pc, instr: head_instr} : hold_q;
        pc_if_id      = valid_if_id ? head_pc : hold_q.pc;
        instr_if_id   = valid_if_id ? head_instr : hold_q.instr;
    end

    // In-flight request tracking and the last-presented head, held while the queue is empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_v_q  <= 1'b0;
            inflight_pc_q <= 32'h0;
            hold_q        <= '{pc: 32'h0, instr: NOP_INSTR};
        end else begin
            inflight_v_q  <= inflight_v_d;
            inflight_pc_q <= inflight_pc_d;
            hold_q        <= hold_d;
        end
    end

`ifdef IFQ_PERF_CNT_EN
    logic [31:0] flush_counter_q, flush_counter_d;
    logic [31:0] stall_counter_q, stall_counter_d;

    // Free-running event counters for flushes and ID back-pressure on a valid head.
    always_comb begin
        flush_counter_d = flush_counter_q;
        stall_counter_d = stall_counter_q;
        if (pc_bj & ~halt) begin
            flush_counter_d = flush_counter_q + 32'd1;
        end
        if (valid_if_id & id_stall & ~halt) begin
            stall_counter_d = stall_counter_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_counter_q <= 32'h0;
            stall_counter_q <= 32'h0;
        end else begin
            flush_counter_q <= flush_counter_d;
            stall_counter_q <= stall_counter_d;
        end
    end

    assign flush_counter = flush_counter_q;
    assign stall_counter = stall_counter_q;
`endif

endmodule
